// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Stall/flush sequencer for a 5-stage pipeline (load-use, branch
//             flush, multi-cycle data memory, timeout error, perf counters).
//  Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             idex_memread_i,
   input  logic [4:0]       idex_rt_i,
   input  logic [4:0]       ifid_rs_i,
   input  logic [4:0]       ifid_rt_i,
   input  logic             branch_taken_i,
   input  logic             jump_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             pipe_hold_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             err_o
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  C_CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_RUN      = 2'b00,
      S_MEM_WAIT = 2'b01,
      S_ERROR    = 2'b10,
      S_ILLEGAL  = 2'b11
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;
   logic              r_err;

   logic w_luh;
   logic w_mstall;
   logic w_ack;
   logic w_pc_write;
   logic w_ifid_write;
   logic w_ifid_flush;
   logic w_idex_bubble;
   logic w_pipe_hold;
   logic w_stall_inc;

   assign w_luh    = idex_memread_i && (idex_rt_i != 5'd0) &&
                     ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
   assign w_ack    = mem_req_i & mem_ack_i;
   assign w_mstall = mem_req_i & ~mem_ack_i;

   always_comb begin
      w_pc_write    = 1'b1;
      w_ifid_write  = 1'b1;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      w_pipe_hold   = 1'b0;
      w_state_nxt   = r_state;
      w_wait_nxt    = r_wait_cnt;

      case (r_state)
         S_RUN: begin
            if (w_mstall) begin
               w_pc_write   = 1'b0;
               w_ifid_write = 1'b0;
               w_pipe_hold  = 1'b1;
               w_state_nxt  = S_MEM_WAIT;
               w_wait_nxt   = WAIT_W'(1);
            end else if (w_luh) begin
               // Branch/jump resolution is deferred until the load result is usable.
               w_pc_write    = 1'b0;
               w_ifid_write  = 1'b0;
               w_idex_bubble = 1'b1;
            end else if (branch_taken_i || jump_i) begin
               w_ifid_flush = 1'b1;
            end
         end

         S_MEM_WAIT: begin
            if (w_ack) begin
               w_state_nxt = S_RUN;
               w_wait_nxt  = '0;
            end else begin
               w_pc_write   = 1'b0;
               w_ifid_write = 1'b0;
               w_pipe_hold  = 1'b1;
               w_wait_nxt   = r_wait_cnt + 1'b1;
               if (r_wait_cnt >= C_WAIT_LAST) begin
                  w_state_nxt = S_ERROR;
               end
            end
         end

         S_ERROR: begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_pipe_hold   = 1'b1;
            w_idex_bubble = 1'b1;
         end

         default: begin
            // Unreachable encoding: freeze for one cycle and recover to RUN.
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_pipe_hold  = 1'b1;
            w_state_nxt  = S_RUN;
            w_wait_nxt   = '0;
         end
      endcase
   end

   assign w_stall_inc = ~w_pc_write && (r_state != S_ERROR);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_RUN;
         r_wait_cnt  <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (w_state_nxt == S_ERROR) begin
            r_err <= 1'b1;
         end
         if (w_stall_inc && (r_stall_cnt != C_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_ifid_flush && (r_flush_cnt != C_CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign pc_write_o    = w_pc_write;
   assign ifid_write_o  = w_ifid_write;
   assign ifid_flush_o  = w_ifid_flush;
   assign idex_bubble_o = w_idex_bubble;
   assign pipe_hold_o   = w_pipe_hold;
   assign state_o       = r_state;
   assign stall_cnt_o   = r_stall_cnt;
   assign flush_cnt_o   = r_flush_cnt;
   assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Directed vector bench for pipeline_hazard_ctrl (TIMEOUT=4, CNT_W=3).
//  Revision : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 3;

   typedef struct {
      logic        rst;
      logic        mr;
      logic [4:0]  irt;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        br;
      logic        jmp;
      logic        req;
      logic        ack;
      logic [13:0] exp;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             mr;
   logic [4:0]       irt, rs, rt;
   logic             br, jmp, req, ack;
   logic             pcw, ifw, fl, bub, hold, err;
   logic [1:0]       st;
   logic [CNT_W-1:0] sc, fc;

   int n_vec = 0;
   int n_bad = 0;

   vec_t tbl [20];

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst),
      .idex_memread_i(mr), .idex_rt_i(irt), .ifid_rs_i(rs), .ifid_rt_i(rt),
      .branch_taken_i(br), .jump_i(jmp), .mem_req_i(req), .mem_ack_i(ack),
      .pc_write_o(pcw), .ifid_write_o(ifw), .ifid_flush_o(fl),
      .idex_bubble_o(bub), .pipe_hold_o(hold), .state_o(st),
      .stall_cnt_o(sc), .flush_cnt_o(fc), .err_o(err)
   );

   // ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
   function automatic vec_t mk(input logic r, m, input logic [4:0] a, b, c,
                               input logic bt, j, q, k, input logic [4:0] ctl,
                               input logic [1:0] s, input logic [2:0] scnt, fcnt,
                               input logic e);
      vec_t v;
      v.rst = r; v.mr = m; v.irt = a; v.rs = b; v.rt = c;
      v.br = bt; v.jmp = j; v.req = q; v.ack = k;
      v.exp = {ctl, s, scnt, fcnt, e};
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst = v.rst; mr = v.mr; irt = v.irt; rs = v.rs; rt = v.rt;
      br = v.br; jmp = v.jmp; req = v.req; ack = v.ack;
   endtask

   task automatic cmp(input string name, input logic [13:0] exp);
      logic [13:0] act;
      act = {pcw, ifw, fl, bub, hold, st, sc, fc, err};
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got ctl=%b st=%b stall=%0d flush=%0d err=%b, expected ctl=%b st=%b stall=%0d flush=%0d err=%b",
                  name, act[13:9], act[8:7], act[6:4], act[3:1], act[0],
                  exp[13:9], exp[8:7], exp[6:4], exp[3:1], exp[0]);
      end
   endtask

   initial begin
      vec_t v;
      tbl[0]  = mk(0,0,0,0,0, 0,0,0,0, 5'b11000, 2'd0, 3'd0, 3'd0, 0); // reset state
      tbl[1]  = mk(0,1,5,5,0, 0,0,0,0, 5'b00010, 2'd0, 3'd0, 3'd0, 0); // luh on rs
      tbl[2]  = mk(0,0,0,0,0, 0,0,0,0, 5'b11000, 2'd0, 3'd1, 3'd0, 0);
      tbl[3]  = mk(0,1,0,3,0, 0,0,0,0, 5'b11000, 2'd0, 3'd1, 3'd0, 0); // $zero exempt
      tbl[4]  = mk(0,1,7,2,7, 0,0,0,0, 5'b00010, 2'd0, 3'd1, 3'd0, 0); // luh on rt
      tbl[5]  = mk(0,1,7,1,2, 0,0,0,0, 5'b11000, 2'd0, 3'd2, 3'd0, 0); // no match
      tbl[6]  = mk(0,0,0,0,0, 1,0,0,0, 5'b11100, 2'd0, 3'd2, 3'd0, 0); // branch flush
      tbl[7]  = mk(0,0,0,0,0, 0,0,0,0, 5'b11000, 2'd0, 3'd2, 3'd1, 0);
      tbl[8]  = mk(0,1,5,5,0, 1,0,0,0, 5'b00010, 2'd0, 3'd2, 3'd1, 0); // luh beats branch
      tbl[9]  = mk(0,0,0,0,0, 0,1,0,0, 5'b11100, 2'd0, 3'd3, 3'd1, 0); // jump flush
      tbl[10] = mk(0,0,0,0,0, 0,0,0,0, 5'b11000, 2'd0, 3'd3, 3'd2, 0);
      tbl[11] = mk(0,0,0,0,0, 0,0,1,1, 5'b11000, 2'd0, 3'd3, 3'd2, 0); // 0-latency access
      tbl[12] = mk(0,0,0,0,0, 0,0,0,1, 5'b11000, 2'd0, 3'd3, 3'd2, 0); // stray ack
      tbl[13] = mk(0,0,0,0,0, 1,0,1,0, 5'b00001, 2'd0, 3'd3, 3'd2, 0); // mstall beats branch
      tbl[14] = mk(0,1,5,5,0, 1,0,1,0, 5'b00001, 2'd1, 3'd4, 3'd2, 0); // luh/br ignored
      tbl[15] = mk(0,0,0,0,0, 0,1,1,0, 5'b00001, 2'd1, 3'd5, 3'd2, 0);
      tbl[16] = mk(0,0,0,0,0, 1,0,1,1, 5'b11000, 2'd1, 3'd6, 3'd2, 0); // ack releases
      tbl[17] = mk(0,0,0,0,0, 0,0,0,0, 5'b11000, 2'd0, 3'd6, 3'd2, 0);
      tbl[18] = mk(1,0,0,0,0, 0,0,0,0, 5'b11000, 2'd0, 3'd6, 3'd2, 0);
      tbl[19] = mk(0,0,0,0,0, 0,0,0,0, 5'b11000, 2'd0, 3'd0, 3'd0, 0); // post reset

      v = mk(1,0,0,0,0, 0,0,0,0, 5'b0, 2'd0, 3'd0, 3'd0, 0);
      drive(v);
      repeat (2) @(negedge clk);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         cmp($sformatf("table[%0d]", i), tbl[i].exp);
      end

      // Timeout: request never acknowledged reaches ERROR after TIMEOUT cycles.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         v = mk(0,0,0,0,0, 0,0,1,0, 5'b0, 2'd0, 3'd0, 3'd0, 0);
         drive(v);
         #1;
         if (i < 4)
            cmp($sformatf("timeout[%0d]", i),
                {5'b00001, (i == 0) ? 2'd0 : 2'd1, 3'(i), 3'd0, 1'b0});
         else
            cmp("timeout_error", {5'b00011, 2'd2, 3'd4, 3'd0, 1'b1});
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         v = mk(0,1,5,5,0, 1,0,1,1, 5'b0, 2'd0, 3'd0, 3'd0, 0);
         drive(v);
         #1;
         cmp($sformatf("error_sticky[%0d]", i), {5'b00011, 2'd2, 3'd4, 3'd0, 1'b1});
      end
      @(negedge clk);
      v = mk(1,0,0,0,0, 0,0,0,0, 5'b0, 2'd0, 3'd0, 3'd0, 0);
      drive(v);
      @(negedge clk);
      v.rst = 1'b0;
      drive(v);
      #1;
      cmp("error_reset", {5'b11000, 2'd0, 3'd0, 3'd0, 1'b0});

      // Saturation: continuous load-use stalls clamp the counter at 7.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         v = mk(0,1,5,5,0, 0,0,0,0, 5'b0, 2'd0, 3'd0, 3'd0, 0);
         drive(v);
         #1;
         cmp($sformatf("saturate[%0d]", i),
             {5'b00010, 2'd0, (i > 7) ? 3'd7 : 3'(i), 3'd0, 1'b0});
      end

      // Reset in the middle of a memory wait returns to RUN.
      @(negedge clk);
      v = mk(0,0,0,0,0, 0,0,1,0, 5'b0, 2'd0, 3'd0, 3'd0, 0);
      drive(v);
      @(negedge clk);
      v.rst = 1'b1;
      drive(v);
      #1;
      cmp("midwait_state", {5'b00001, 2'd1, 3'd7, 3'd0, 1'b0});
      @(negedge clk);
      v = mk(0,0,0,0,0, 0,0,0,0, 5'b0, 2'd0, 3'd0, 3'd0, 0);
      drive(v);
      #1;
      cmp("midwait_reset", {5'b11000, 2'd0, 3'd0, 3'd0, 1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enables and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken branches/jumps and multi-cycle data-memory accesses. It also keeps saturating stall/flush counters and a sticky memory-timeout error.

Parameters:
TIMEOUT, 64, max cycles a data-memory access may wait for ack before error (>=2)
CNT_W, 16, width of the stall and flush performance counters

Ports:
clk_i  in  1  clock, all state updates on posedge
rst_i  in  1  synchronous active-high reset
idex_memread_i  in  1  instruction in EX is a load
idex_rt_i  in  5  destination register of the load in EX
ifid_rs_i  in  5  rs of instruction in ID
ifid_rt_i  in  5  rt of instruction in ID
branch_taken_i  in  1  branch in ID resolved taken
jump_i  in  1  jump decoded in ID
mem_req_i  in  1  instruction in MEM accesses data memory
mem_ack_i  in  1  data memory completes access this cycle
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID load enable
ifid_flush_o  out  1  IF/ID loads a NOP (inst=0)
idex_bubble_o  out  1  ID/EX loads zero WB/M/EX control fields
pipe_hold_o  out  1  EX/MEM and MEM/WB hold their contents
state_o  out  2  00 RUN, 01 MEM_WAIT, 10 ERROR
stall_cnt_o  out  CNT_W  saturating count of stall cycles
flush_cnt_o  out  CNT_W  saturating count of IF/ID flushes
err_o  out  1  sticky memory-timeout error

Behaviour:
- Reset (sync, rst_i high at posedge): state=RUN, wait counter=0, stall_cnt_o=0, flush_cnt_o=0, err_o=0. Reset wins over every other event in any state, including mid-MEM_WAIT and ERROR.
- Control outputs are combinational from the registered state plus the current inputs. Counters, state and err_o are registered.
- Load-use hazard: luh = idex_memread_i & idex_rt_i!=0 & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
- Memory stall: mstall = mem_req_i & ~mem_ack_i.
- RUN, priority order:
  1. mstall: pc_write=0, ifid_write=0, idex_bubble=0, pipe_hold=1, flush=0. Next state MEM_WAIT, wait counter=1.
  2. luh: pc_write=0, ifid_write=0, idex_bubble=1, pipe_hold=0, ifid_flush=0. Any branch/jump is ignored this cycle and re-evaluated next cycle.
  3. branch_taken_i | jump_i: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0.
  4. Otherwise: pc_write=1, ifid_write=1, all other controls 0.
- MEM_WAIT: pc_write=0, ifid_write=0, pipe_hold=1, idex_bubble=0, ifid_flush=0. luh, branch and jump are ignored.
  - On mem_ack_i: all holds release in the same cycle (outputs as RUN case 4; luh/branch are not honoured that cycle). Next state RUN, wait counter cleared.
  - Otherwise the wait counter increments. When it reaches TIMEOUT without ack, next state ERROR.
  - Access latency: an ack N cycles after the request costs exactly N stall cycles.
- ERROR: pc_write=0, ifid_write=0, pipe_hold=1, idex_bubble=1, err_o=1. Exit only by reset.
- mem_ack_i without mem_req_i is ignored.
- stall_cnt_o increments on every cycle with pc_write_o=0, outside reset and not in ERROR. flush_cnt_o increments on every cycle with ifid_flush_o=1. Both saturate at all-ones with no wrap.
- state_o encoding 11 is unreachable. If it is entered, the next cycle goes to RUN.

Test Plan:
- Load-use: idex_memread=1, idex_rt=5, ifid_rs=5 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1. Next cycle with idex_memread=0 -> normal. stall_cnt=1.
- $zero exemption: idex_memread=1, idex_rt=0, ifid_rt=0 -> no stall, pc_write=1, stall_cnt stays 0.
- Branch flush, and luh-over-branch: branch_taken=1 alone -> ifid_flush=1, flush_cnt=1. branch_taken=1 together with luh -> ifid_flush=0, idex_bubble=1.
- Memory wait: mem_req=1, ack after 3 cycles -> state 01 for 3 cycles, pipe_hold=1 throughout, then RUN. stall_cnt=3. A luh/branch asserted during the wait produces no bubble or flush.
- Timeout with TIMEOUT=4: mem_req=1, never ack -> ERROR after 4 cycles with err_o=1 sticky. rst_i for one cycle -> state 00, err_o=0, counters 0.
- Saturation with CNT_W=3: hold luh for 10 cycles -> stall_cnt_o stops at 7. Reset asserted mid-MEM_WAIT -> RUN next cycle.
